camera_key_ctrl: RTL
====================

Name: camera_key_ctrl

Overview:
- Command-side driver for the camera datapath: turns PS/2 set-2 scan-code bytes into a 3-bit camera move code, a held-cycle count and a one-cycle load strobe.
- Sits between the PS/2 receiver and the camera datapath.
- The datapath latches key/cnt on ld_curr_camera, then applies cnt × move_scale along the selected ±U/V/W axis on its next vertical phase.

Parameters:
- MAX_CNT, 32'hFFFF_FFFF: saturation ceiling for the cycle accumulator.
- FLUSH_ON_SWITCH, 1: 1 = emit the old key's pending motion immediately when a different mapped key is pressed; 0 = discard it.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- scan_code  in  8  byte from PS/2 receiver, valid only with scan_valid
- scan_valid  in  1  one-cycle strobe per received byte
- frame_tick  in  1  one-cycle pulse per frame; defines load windows
- key  out  3  move code: 000 U+, 001 U-, 010 V+, 011 V-, 100 W+, 101 W-
- cnt  out  32  clock cycles the key was held in the closed window; stable between loads
- ld_curr_camera  out  1  one-cycle load strobe for key/cnt
- key_held  out  1  a mapped key is currently down

Behaviour:
- Interface (decided): single clock clk; rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: key=000, cnt=0, ld_curr_camera=0, key_held=0; internal accum=0; prefix FSM=P_NORM.
- Key map (make codes): D 23→000, A 1C→001, R 2D→010, F 2B→011, W 1D→100, S 1B→101. All other codes are unmapped.
- Prefix FSM states: P_NORM, P_BRK, P_EXT, P_EXT_BRK. It advances only on scan_valid.
  - P_NORM: F0→P_BRK; E0→P_EXT; any other byte is a make code → P_NORM.
  - P_BRK: byte is a break code → P_NORM.
  - P_EXT: F0→P_EXT_BRK; any other byte → P_NORM and is ignored.
  - P_EXT_BRK: any byte → P_NORM and is ignored. Extended keys never affect held state.
- Make of a mapped code:
  - Same code as the held key (typematic repeat): no effect.
  - Different code, or nothing held: held_code and key_held update the next cycle.
- Break matching the held code: key_held→0. accum is retained and flushed at the next tick.
- Break of any other code: ignored.
- accum increments by 1 on every cycle key_held=1 and frame_tick=0. It saturates at MAX_CNT; no wrap.
- On frame_tick with accum≠0:
  - ld_curr_camera=1 in the following cycle; key=held_code in effect before the tick; cnt=accum.
  - accum clears to 0. If the key is still held, the tick cycle itself counts as cycle 1 of the new window (accum=1 after the tick).
- On frame_tick with accum=0: no strobe; key and cnt hold their values.
- Key switch with FLUSH_ON_SWITCH=1 and accum≠0: immediate load strobe with the old code and cnt=accum; accum→0.
- Tick and switch in the same cycle: exactly one strobe, carrying the old code.
- key and cnt change only in the same cycle as ld_curr_camera=1.
- ld_curr_camera is never high on two consecutive cycles.
- Latency: scan_valid → key_held update is 1 cycle; tick/flush → strobe is 1 cycle.
- scan_valid and frame_tick in the same cycle: the tick uses the pre-byte state; the byte is applied afterward.
- rst asserted mid-hold or mid-prefix: all state returns to reset values; no strobe is emitted during or after rst.

Optional Feature:
- Macro: CAM_SPEED_BOOST_EN.
- Defined: Left Shift (12) make/break is tracked as boost_held (extended and prefix rules as above). At load time, if boost_held=1, cnt=min(accum<<1, MAX_CNT) with saturation checked before the shift. Shift does not change key_held.
- Undefined: code 12 is unmapped; no boost state exists; cnt=accum always.

Test Plan:
- Reset → key=000, cnt=0, ld_curr_camera=0, key_held=0. Then frame_tick with no keys → no strobe.
- Bytes 1D; wait 100 cycles; frame_tick → one strobe with key=100, cnt=100 (±1 per the counting rule above); key_held stays 1; next tick 50 cycles later → cnt=50.
- Press 1C, hold 30 cycles, bytes F0 1C, idle 20 cycles, tick → key=001, cnt=30 plus break-byte latency; following tick → no strobe.
- Press 23, 40 cycles later press 2B (FLUSH_ON_SWITCH=1) → immediate strobe key=000, cnt=40; next tick → key=011. Same press sequence with a tick in the same cycle as the 2B byte → exactly one strobe, key=000.
- Bytes E0 1D and E0 F0 1D → key_held unchanged, no strobes. Repeated 1D while 1D is held → accum is not reset.
- MAX_CNT=10, hold 25 cycles, tick → cnt=10. With CAM_SPEED_BOOST_EN defined: bytes 12, 1D, hold 8 cycles, tick → cnt=10 (16 saturated); hold 4 cycles → cnt=8.

Source files
------------

// File: rtl/camera_key_ctrl.sv
// camera_key_ctrl
// Converts PS/2 set-2 scan-code bytes into a camera move code, a count of the
// cycles the key was held, and a one-cycle load strobe for the camera datapath.
// Optional build macro: CAM_SPEED_BOOST_EN (Left Shift doubles the loaded count).
module camera_key_ctrl #(
    parameter logic [31:0] MAX_CNT         = 32'hFFFF_FFFF,
    parameter bit          FLUSH_ON_SWITCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    input  logic        frame_tick,
    output logic [2:0]  key,
    output logic [31:0] cnt,
    output logic        ld_curr_camera,
    output logic        key_held
);

    typedef enum logic [1:0] {
        P_NORM    = 2'd0,
        P_BRK     = 2'd1,
        P_EXT     = 2'd2,
        P_EXT_BRK = 2'd3
    } pfx_e;

    // Returns {mapped, move_code} for a set-2 make/break code.
    function automatic logic [3:0] map_code(input logic [7:0] b);
        case (b)
            8'h23:   map_code = {1'b1, 3'b000};
            8'h1C:   map_code = {1'b1, 3'b001};
            8'h2D:   map_code = {1'b1, 3'b010};
            8'h2B:   map_code = {1'b1, 3'b011};
            8'h1D:   map_code = {1'b1, 3'b100};
            8'h1B:   map_code = {1'b1, 3'b101};
            default: map_code = {1'b0, 3'b000};
        endcase
    endfunction

`ifdef CAM_SPEED_BOOST_EN
    // Doubled count, clamped to the ceiling without overflowing 32 bits.
    function automatic logic [31:0] boost_scale(input logic [31:0] a);
        logic [32:0] dbl;
        dbl = {a, 1'b0};
        if (dbl > {1'b0, MAX_CNT}) begin
            boost_scale = MAX_CNT;
        end else begin
            boost_scale = dbl[31:0];
        end
    endfunction
`endif

    pfx_e        pfx_q, pfx_d;
    logic        held_q, held_d;
    logic [2:0]  code_q, code_d;
    logic [31:0] accum_q, accum_d;
    logic [2:0]  key_q, key_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ld_q, ld_d;
`ifdef CAM_SPEED_BOOST_EN
    logic        boost_q, boost_d;
`endif

    logic        make_s;
    logic        brk_s;
    logic [3:0]  map_s;
    logic        press_s;
    logic        switch_s;
    logic        release_s;
    logic        fire_s;
    logic        tick_blocked_s;
    logic [31:0] load_cnt_s;

    // Next-state logic: prefix decoding, held-key tracking, accumulator and load.
    always_comb begin
        pfx_d      = pfx_q;
        held_d     = held_q;
        code_d     = code_q;
        accum_d    = accum_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        ld_d       = 1'b0;
        make_s     = 1'b0;
        brk_s      = 1'b0;
`ifdef CAM_SPEED_BOOST_EN
        boost_d    = boost_q;
`endif

        if (scan_valid) begin
            case (pfx_q)
                P_NORM: begin
                    if (scan_code == 8'hF0) begin
                        pfx_d = P_BRK;
                    end else if (scan_code == 8'hE0) begin
                        pfx_d = P_EXT;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                P_BRK: begin
                    brk_s = 1'b1;
                    pfx_d = P_NORM;
                end
                P_EXT: begin
                    if (scan_code == 8'hF0) begin
                        pfx_d = P_EXT_BRK;
                    end else begin
                        pfx_d = P_NORM;
                    end
                end
                P_EXT_BRK: pfx_d = P_NORM;
                default:   pfx_d = P_NORM;
            endcase
        end else begin
            pfx_d = pfx_q;
        end

        map_s     = map_code(scan_code);
        // A typematic repeat of the held key is not a new press.
        press_s   = make_s && map_s[3] && !(held_q && (map_s[2:0] == code_q));
        // A new key while motion is pending for a different code.
        switch_s  = press_s && (map_s[2:0] != code_q) && (accum_q != 32'd0);
        release_s = brk_s && map_s[3] && held_q && (map_s[2:0] == code_q);
        // A strobe on the previous cycle blocks another one this cycle.
        fire_s    = ((frame_tick && (accum_q != 32'd0)) || (switch_s && FLUSH_ON_SWITCH)) && !ld_q;
        tick_blocked_s = (accum_q != 32'd0) && ld_q;

`ifdef CAM_SPEED_BOOST_EN
        if (boost_q) begin
            load_cnt_s = boost_scale(accum_q);
        end else begin
            load_cnt_s = accum_q;
        end
`else
        load_cnt_s = accum_q;
`endif

        if (fire_s) begin
            ld_d  = 1'b1;
            key_d = code_q;
            cnt_d = load_cnt_s;
        end else begin
            ld_d  = 1'b0;
        end

        // Switch always ends the old window (flushed or discarded).
        if (switch_s) begin
            accum_d = 32'd0;
        end else if (frame_tick) begin
            if (tick_blocked_s) begin
                accum_d = accum_q;
            end else begin
                accum_d = {31'd0, held_q};
            end
        end else if (held_q && (accum_q != MAX_CNT)) begin
            accum_d = accum_q + 32'd1;
        end else begin
            accum_d = accum_q;
        end

        if (press_s) begin
            held_d = 1'b1;
            code_d = map_s[2:0];
        end else if (release_s) begin
            held_d = 1'b0;
        end else begin
            held_d = held_q;
        end

`ifdef CAM_SPEED_BOOST_EN
        if (make_s && (scan_code == 8'h12)) begin
            boost_d = 1'b1;
        end else if (brk_s && (scan_code == 8'h12)) begin
            boost_d = 1'b0;
        end else begin
            boost_d = boost_q;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pfx_q   <= P_NORM;
            held_q  <= 1'b0;
            code_q  <= 3'b000;
            accum_q <= 32'd0;
            key_q   <= 3'b000;
            cnt_q   <= 32'd0;
            ld_q    <= 1'b0;
`ifdef CAM_SPEED_BOOST_EN
            boost_q <= 1'b0;
`endif
        end else begin
            pfx_q   <= pfx_d;
            held_q  <= held_d;
            code_q  <= code_d;
            accum_q <= accum_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
`ifdef CAM_SPEED_BOOST_EN
            boost_q <= boost_d;
`endif
        end
    end

    assign key            = key_q;
    assign cnt            = cnt_q;
    assign ld_curr_camera = ld_q;
    assign key_held       = held_q;

endmodule
